button_event: RTL and testbench



---
 rtl/button_pkg.sv | 24 ++
 rtl/button_event.sv | 161 ++++++++++++++++
 tb/tb_button_event.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the push-button event logic:
//   - FSM state encoding (IDLE / SHORT / LONG) and the matching enum type
//   - default timing constants for the 50 MHz board clock
// -----------------------------------------------------------------------------
package button_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHORT = 2'd1;
    localparam logic [1:0] LONG  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_SHORT = SHORT,
        S_LONG  = LONG
    } button_state_e;

    // 0.5 s long-press threshold and 0.1 s auto-repeat period at 50 MHz.
    localparam int LONG_PRESS_CYCLES_DEFAULT = 25_000_000;
    localparam int REPEAT_CYCLES_DEFAULT     = 5_000_000;
    localparam int CNT_WIDTH_DEFAULT         = 25;

endpackage

// File: rtl/button_event.sv
// -----------------------------------------------------------------------------
// button_event
// Turns the debounced, active-high button level into single-cycle event
// pulses: press, release, short click, long press and (optionally) repeat.
//
// Optional feature macro: BUTTON_EVENT_AUTO_REPEAT_EN
//   defined   -> repeat_pulse fires every REPEAT_CYCLES while held in LONG
//   undefined -> repeat_pulse tied to 0, no LONG counter logic
//
// Ports:
//   clock              in   system clock, rising edge
//   reset              in   synchronous, active-high reset
//   button_level       in   debounced level, 1 = pressed (clock domain)
//   press_pulse        out  one cycle after the press is sampled
//   release_pulse      out  one cycle after the release is sampled
//   short_click_pulse  out  with release_pulse, if released before long press
//   long_press_pulse   out  one cycle when the hold reaches LONG_PRESS_CYCLES
//   repeat_pulse       out  periodic pulse while held in LONG
//   held               out  1 while the FSM is in SHORT or LONG
// All outputs are registered.
// -----------------------------------------------------------------------------
module button_event
    import button_pkg::*;
#(
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT,
    parameter int REPEAT_CYCLES     = REPEAT_CYCLES_DEFAULT,
    parameter int CNT_WIDTH         = CNT_WIDTH_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic button_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_click_pulse,
    output logic long_press_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);

    button_state_e        state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic press_q, press_d;
    logic release_q, release_d;
    logic short_q, short_d;
    logic long_q, long_d;
    logic held_q, held_d;

`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    localparam logic [CNT_WIDTH-1:0] RP_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);
    logic repeat_q, repeat_d;
`else
    // The repeat period only matters when auto-repeat is built in.
    localparam int unused_repeat_cycles = REPEAT_CYCLES;
`endif

    // Next-state, counter and event decode. A release always takes priority
    // over a threshold hit sampled on the same edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
        repeat_d  = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (button_level) begin
                    state_d = S_SHORT;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end

            S_SHORT: begin
                if (!button_level) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    short_d   = 1'b1;
                end else if (cnt_q == LP_LAST) begin
                    state_d = S_LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end

            S_LONG: begin
                if (!button_level) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
                    if (cnt_q == RP_LAST) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
`else
                    cnt_d = '0;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
            repeat_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            held_q    <= held_d;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
            repeat_q  <= repeat_d;
`endif
        end
    end

    assign press_pulse       = press_q;
    assign release_pulse     = release_q;
    assign short_click_pulse = short_q;
    assign long_press_pulse  = long_q;
    assign held              = held_q;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    assign repeat_pulse      = repeat_q;
`else
    assign repeat_pulse      = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
`timescale 1ns/1ps
module tb_button_event;

    localparam int LP = 8;
    localparam int RP = 4;
    localparam int CW = 4;

`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    // Observation word: {press, release, short, long, repeat, held}
    localparam logic [5:0] P_NONE  = 6'b000000;
    localparam logic [5:0] P_PRESS = 6'b100001;
    localparam logic [5:0] P_HELD  = 6'b000001;
    localparam logic [5:0] P_SHORT = 6'b011000;
    localparam logic [5:0] P_REL   = 6'b010000;
    localparam logic [5:0] P_LONG  = 6'b000101;
    localparam logic [5:0] P_REP   = 6'b000011;

    logic clock = 1'b0;
    logic reset;
    logic button_level;
    logic press_pulse, release_pulse, short_click_pulse;
    logic long_press_pulse, repeat_pulse, held;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    button_event #(
        .LONG_PRESS_CYCLES(LP),
        .REPEAT_CYCLES    (RP),
        .CNT_WIDTH        (CW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .button_level     (button_level),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .short_click_pulse(short_click_pulse),
        .long_press_pulse (long_press_pulse),
        .repeat_pulse     (repeat_pulse),
        .held             (held)
    );

    function automatic logic [5:0] obs_word();
        return {press_pulse, release_pulse, short_click_pulse,
                long_press_pulse, repeat_pulse, held};
    endfunction

    // Present a level for the next edge, then move 1 ns past that edge.
    task automatic tick(input logic lvl);
        button_level = lvl;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        reset = 1'b1;
        tick(1'b0);
        tick(1'b0);
        obs = obs_word();
        checks++;
        if (obs !== P_NONE) begin
            errors++;
            $display("FAIL reset_idle got %b expected %b", obs, P_NONE);
        end
        // Level high while in reset: nothing may fire.
        tick(1'b1);
        obs = obs_word();
        checks++;
        if (obs !== P_NONE) begin
            errors++;
            $display("FAIL reset_level_high got %b expected %b", obs, P_NONE);
        end
        // First non-reset edge with level already high is a new press.
        reset = 1'b0;
        tick(1'b1);
        obs = obs_word();
        checks++;
        if (obs !== P_PRESS) begin
            errors++;
            $display("FAIL reset_then_press got %b expected %b", obs, P_PRESS);
        end
        tick(1'b0);
        obs = obs_word();
        checks++;
        if (obs !== P_SHORT) begin
            errors++;
            $display("FAIL reset_then_release got %b expected %b", obs, P_SHORT);
        end
        tick(1'b0);
    endtask

    task automatic test_short_click();
        logic       lv [0:4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [5:0] ex [0:4] = '{P_PRESS, P_HELD, P_HELD, P_SHORT, P_NONE};
        logic [5:0] obs;
        for (int i = 0; i < 5; i++) begin
            tick(lv[i]);
            obs = obs_word();
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL short_click cycle %0d got %b expected %b", i + 1, obs, ex[i]);
            end
        end
    endtask

    task automatic test_long_boundary();
        logic [5:0] ex;
        logic [5:0] obs;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      ex = P_PRESS;
            else if (i < 8)  ex = P_HELD;
            else if (i == 8) ex = P_SHORT;
            else             ex = P_NONE;
            tick(i < 8);
            obs = obs_word();
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL long_boundary cycle %0d got %b expected %b", i + 1, obs, ex);
            end
        end
    endtask

    task automatic test_long_press();
        logic [5:0] ex;
        logic [5:0] obs;
        for (int i = 0; i < 11; i++) begin
            if (i == 0)      ex = P_PRESS;
            else if (i < 8)  ex = P_HELD;
            else if (i == 8) ex = P_LONG;
            else if (i == 9) ex = P_REL;
            else             ex = P_NONE;
            tick(i < 9);
            obs = obs_word();
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL long_press cycle %0d got %b expected %b", i + 1, obs, ex);
            end
        end
    endtask

    // Held 21 edges: long press at edge 9, repeats at edges 13, 17, 21.
    task automatic test_auto_repeat();
        logic [5:0] ex;
        logic [5:0] obs;
        for (int i = 0; i < 23; i++) begin
            if (i == 0)       ex = P_PRESS;
            else if (i < 8)   ex = P_HELD;
            else if (i == 8)  ex = P_LONG;
            else if (i < 21)  ex = (REP_EN && (i == 12 || i == 16 || i == 20)) ? P_REP : P_HELD;
            else if (i == 21) ex = P_REL;
            else              ex = P_NONE;
            tick(i < 21);
            obs = obs_word();
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL auto_repeat cycle %0d got %b expected %b", i + 1, obs, ex);
            end
        end
    endtask

    // Release sampled on the edge where the second repeat would fire.
    task automatic test_repeat_boundary();
        logic [5:0] ex;
        logic [5:0] obs;
        for (int i = 0; i < 18; i++) begin
            if (i == 0)       ex = P_PRESS;
            else if (i < 8)   ex = P_HELD;
            else if (i == 8)  ex = P_LONG;
            else if (i < 16)  ex = (REP_EN && i == 12) ? P_REP : P_HELD;
            else if (i == 16) ex = P_REL;
            else              ex = P_NONE;
            tick(i < 16);
            obs = obs_word();
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL repeat_boundary cycle %0d got %b expected %b", i + 1, obs, ex);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [5:0] ex;
        logic [5:0] obs;
        for (int i = 0; i < 12; i++) begin
            if (i == 0)      ex = P_PRESS;
            else if (i < 8)  ex = P_HELD;
            else if (i == 8) ex = P_LONG;
            else             ex = P_HELD;
            tick(1'b1);
            obs = obs_word();
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL mid_hold_pre cycle %0d got %b expected %b", i + 1, obs, ex);
            end
        end
        reset = 1'b1;
        tick(1'b1);
        obs = obs_word();
        checks++;
        if (obs !== P_NONE) begin
            errors++;
            $display("FAIL mid_hold_reset got %b expected %b", obs, P_NONE);
        end
        reset = 1'b0;
        tick(1'b1);
        obs = obs_word();
        checks++;
        if (obs !== P_PRESS) begin
            errors++;
            $display("FAIL mid_hold_repress got %b expected %b", obs, P_PRESS);
        end
        tick(1'b1);
        obs = obs_word();
        checks++;
        if (obs !== P_HELD) begin
            errors++;
            $display("FAIL mid_hold_held got %b expected %b", obs, P_HELD);
        end
        tick(1'b0);
        obs = obs_word();
        checks++;
        if (obs !== P_SHORT) begin
            errors++;
            $display("FAIL mid_hold_short got %b expected %b", obs, P_SHORT);
        end
        tick(1'b0);
    endtask

    task automatic test_back_to_back();
        logic       lv [0:6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [5:0] ex [0:6] = '{P_PRESS, P_SHORT, P_PRESS, P_SHORT, P_PRESS, P_SHORT, P_NONE};
        logic [5:0] obs;
        int         grp;
        for (int i = 0; i < 7; i++) begin
            tick(lv[i]);
            obs = obs_word();
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL toggle cycle %0d got %b expected %b", i + 1, obs, ex[i]);
            end
            grp = int'(press_pulse) + int'(long_press_pulse) + int'(repeat_pulse);
            checks++;
            if (grp > 1) begin
                errors++;
                $display("FAIL toggle_overlap cycle %0d got %0d pulses expected at most 1", i + 1, grp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        button_level = 1'b0;
        test_reset();
        test_short_click();
        test_long_boundary();
        test_long_press();
        test_auto_repeat();
        test_repeat_boundary();
        test_reset_mid_hold();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
